key_event_encoder: RTL and testbench



---
 rtl/key_event_encoder.sv | 144 ++++++++++++++
 tb/tb_key_event_encoder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_encoder.sv
// Key event encoder: debounces the scanner bitmap globally, then sweeps keys 1..NUM_KEYS
// and emits one make/break event per key whose bitmap bit differs from the reported state.
module key_event_encoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int NUM_KEYS      = 103
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enabled,
    input  logic [NUM_KEYS:1]   key_down,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [6:0]          evt_code,
    output logic                evt_make,
    output logic [NUM_KEYS:1]   key_state,
    output logic                busy
);

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_EMIT  = 2'd2
    } state_t;

    localparam logic [15:0] STAB_MAX = 16'(STABLE_CYCLES - 1);
    localparam logic [6:0]  LAST_IDX = 7'(NUM_KEYS);

    state_t              r_state,     w_state_nxt;
    logic [NUM_KEYS:1]   r_snap,      w_snap_nxt;
    logic [15:0]         r_stab_cnt,  w_stab_cnt_nxt;
    logic [6:0]          r_idx,       w_idx_nxt;
    logic                r_evt_valid, w_evt_valid_nxt;
    logic [6:0]          r_evt_code,  w_evt_code_nxt;
    logic                r_evt_make,  w_evt_make_nxt;
    logic [NUM_KEYS:1]   r_key_state, w_key_state_nxt;
    logic                r_busy,      w_busy_nxt;

    logic w_snap_match;
    logic w_bit_diff;
    logic w_last;

    assign w_snap_match = (key_down == r_snap);
    assign w_bit_diff   = (r_snap[r_idx] != r_key_state[r_idx]);
    assign w_last       = (r_idx == LAST_IDX);

    // Next-state and datapath updates for the WAIT / SWEEP / EMIT controller
    always_comb begin
        w_state_nxt     = r_state;
        w_snap_nxt      = r_snap;
        w_stab_cnt_nxt  = r_stab_cnt;
        w_idx_nxt       = r_idx;
        w_evt_valid_nxt = r_evt_valid;
        w_evt_code_nxt  = r_evt_code;
        w_evt_make_nxt  = r_evt_make;
        w_key_state_nxt = r_key_state;
        case (r_state)
            ST_WAIT: begin
                w_snap_nxt = key_down;
                if (w_snap_match) begin
                    if (r_stab_cnt < STAB_MAX) begin
                        w_stab_cnt_nxt = r_stab_cnt + 16'd1;
                    end else begin
                        w_stab_cnt_nxt = r_stab_cnt;
                    end
                end else begin
                    w_stab_cnt_nxt = 16'd0;
                end
                // Start only from a bitmap that differs from what the host already knows
                if (w_snap_match && (r_stab_cnt == STAB_MAX) && enabled &&
                    (r_snap != r_key_state)) begin
                    w_state_nxt = ST_SWEEP;
                    w_idx_nxt   = 7'd1;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_SWEEP: begin
                if (w_bit_diff) begin
                    w_evt_code_nxt  = r_idx;
                    w_evt_make_nxt  = r_snap[r_idx];
                    w_evt_valid_nxt = 1'b1;
                    w_state_nxt     = ST_EMIT;
                end else if (w_last) begin
                    w_state_nxt    = ST_WAIT;
                    w_stab_cnt_nxt = 16'd0;
                end else begin
                    w_idx_nxt = r_idx + 7'd1;
                end
            end
            ST_EMIT: begin
                if (r_evt_valid && evt_ready) begin
                    w_evt_valid_nxt        = 1'b0;
                    w_key_state_nxt[r_idx] = r_evt_make;
                    if (w_last) begin
                        w_state_nxt    = ST_WAIT;
                        w_stab_cnt_nxt = 16'd0;
                    end else begin
                        w_idx_nxt   = r_idx + 7'd1;
                        w_state_nxt = ST_SWEEP;
                    end
                end else begin
                    w_state_nxt = ST_EMIT;
                end
            end
            default: begin
                w_state_nxt     = ST_WAIT;
                w_evt_valid_nxt = 1'b0;
            end
        endcase
        w_busy_nxt = (w_state_nxt != ST_WAIT);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_WAIT;
            r_snap      <= '0;
            r_stab_cnt  <= 16'd0;
            r_idx       <= 7'd1;
            r_evt_valid <= 1'b0;
            r_evt_code  <= 7'd0;
            r_evt_make  <= 1'b0;
            r_key_state <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_snap      <= w_snap_nxt;
            r_stab_cnt  <= w_stab_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_evt_valid <= w_evt_valid_nxt;
            r_evt_code  <= w_evt_code_nxt;
            r_evt_make  <= w_evt_make_nxt;
            r_key_state <= w_key_state_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign evt_valid = r_evt_valid;
    assign evt_code  = r_evt_code;
    assign evt_make  = r_evt_make;
    assign key_state = r_key_state;
    assign busy      = r_busy;

endmodule

// File: tb/tb_key_event_encoder.sv
// Bench for key_event_encoder: event-list reference model compared every cycle,
// directed scenarios with literal expectations, then a randomized phase.
module tb_key_event_encoder;

    localparam int S = 4;
    localparam int N = 103;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enabled = 1'b1;
    logic [N:1]    kd = '0;
    logic          evt_valid;
    logic          evt_ready = 1'b1;
    logic [6:0]    evt_code;
    logic          evt_make;
    logic [N:1]    key_state;
    logic          busy;

    int total = 0;
    int bad   = 0;

    key_event_encoder #(.STABLE_CYCLES(S), .NUM_KEYS(N)) dut (
        .clock    (clock),
        .reset    (reset),
        .enabled  (enabled),
        .key_down (kd),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_code (evt_code),
        .evt_make (evt_make),
        .key_state(key_state),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The model thinks in terms of "how many consecutive idle edges has the bitmap been
    // unchanged" and "which keys differ from the reported set", then schedules the event
    // list in time: the sweep walks one key per clock, stalling at each event until accepted.
    logic [N:1] m_prev = '0;
    logic [N:1] m_state = '0;
    int         m_run = 0;
    bit         m_busy = 0;
    bit         m_valid = 0;
    int         m_code = 0;
    bit         m_make = 0;
    int         m_cd = 0;
    int         q[$];
    bit         cmp_on = 0;

    initial begin
        forever begin
            @(posedge clock);
            if (reset) begin
                m_prev = '0; m_state = '0; m_run = 0;
                m_busy = 0; m_valid = 0; m_cd = 0; q.delete();
                cmp_on = 1;
            end else if (!m_busy) begin
                if (kd == m_prev) m_run = (m_run < 100000) ? m_run + 1 : m_run;
                else m_run = 0;
                if (kd == m_prev && m_run >= S && enabled && m_prev != m_state) begin
                    q.delete();
                    for (int i = 1; i <= N; i++)
                        if (m_prev[i] != m_state[i]) q.push_back(i);
                    m_busy = 1;
                    m_cd = q[0];
                end
                m_prev = kd;
            end else if (m_valid) begin
                if (evt_ready) begin
                    int last;
                    last = q.pop_front();
                    m_state[last] = m_make;
                    m_valid = 0;
                    if (q.size() > 0) m_cd = q[0] - last;
                    else begin
                        m_cd = N - last;
                        if (m_cd == 0) begin m_busy = 0; m_run = 0; end
                    end
                end
            end else begin
                m_cd--;
                if (m_cd == 0) begin
                    if (q.size() > 0) begin
                        m_valid = 1;
                        m_code = q[0];
                        m_make = ~m_state[q[0]];
                    end else begin
                        m_busy = 0;
                        m_run = 0;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clock) begin
        if (cmp_on) begin
            chk("valid", {127'd0, evt_valid}, {127'd0, m_valid});
            chk("busy", {127'd0, busy}, {127'd0, m_busy});
            chk("key_state", {25'd0, key_state}, {25'd0, m_state});
            if (m_valid) begin
                chk("code", {121'd0, evt_code}, 128'(m_code));
                chk("make", {127'd0, evt_make}, {127'd0, m_make});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic wait_valid(input string name, input int lim);
        int n;
        n = 0;
        while (!evt_valid && n < lim) begin step(1); n++; end
        chk({name, "_timeout"}, {127'd0, evt_valid}, 128'd1);
    endtask

    task automatic wait_idle(input int lim);
        int n;
        n = 0;
        while ((busy || evt_valid) && n < lim) begin step(1); n++; end
        chk("idle_timeout", {127'd0, busy}, 128'd0);
    endtask

    task automatic expect_event(input string name, input int code, input bit make);
        wait_valid(name, 300);
        chk({name, "_code"}, {121'd0, evt_code}, 128'(code));
        chk({name, "_make"}, {127'd0, evt_make}, {127'd0, make});
        step(1);
    endtask

    initial begin
        // Reset behaviour
        reset = 1'b1; kd = '0; evt_ready = 1'b1; enabled = 1'b1;
        step(2);
        reset = 1'b0;
        chk("rst_valid", {127'd0, evt_valid}, 128'd0);
        chk("rst_state", {25'd0, key_state}, 128'd0);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (busy || evt_valid) chk("idle_quiet", {126'd0, busy, evt_valid}, 128'd0);
        end

        // Single press: valid must appear right after edge E0+S+5
        kd[5] = 1'b1;
        step(1);
        step(S + 4);
        chk("press5_early", {127'd0, evt_valid}, 128'd0);
        step(1);
        chk("press5_valid", {127'd0, evt_valid}, 128'd1);
        chk("press5_code", {121'd0, evt_code}, 128'd5);
        chk("press5_make", {127'd0, evt_make}, 128'd1);
        step(1);
        chk("press5_state", {127'd0, key_state[5]}, 128'd1);
        wait_idle(300);
        kd[5] = 1'b0;
        expect_event("rel5", 5, 1'b0);
        wait_idle(300);

        // Backpressure
        evt_ready = 1'b0;
        kd[5] = 1'b1;
        wait_valid("bp", 300);
        for (int i = 0; i < 20; i++) step(1);
        chk("bp_valid", {127'd0, evt_valid}, 128'd1);
        chk("bp_code", {121'd0, evt_code}, 128'd5);
        chk("bp_make", {127'd0, evt_make}, 128'd1);
        chk("bp_state", {127'd0, key_state[5]}, 128'd0);
        evt_ready = 1'b1;
        step(1);
        chk("bp_done_valid", {127'd0, evt_valid}, 128'd0);
        chk("bp_done_state", {127'd0, key_state[5]}, 128'd1);
        wait_idle(300);
        kd[5] = 1'b0;
        expect_event("bp_rel", 5, 1'b0);
        wait_idle(300);

        // Multi-key ordering within one sweep
        kd[100] = 1'b1; kd[3] = 1'b1;
        expect_event("mk_a", 3, 1'b1);
        expect_event("mk_b", 100, 1'b1);
        wait_idle(300);
        kd[100] = 1'b0; kd[3] = 1'b0;
        expect_event("mb_a", 3, 1'b0);
        expect_event("mb_b", 100, 1'b0);
        wait_idle(300);
        chk("mk_state_zero", {25'd0, key_state}, 128'd0);

        // Bounce rejection
        for (int i = 0; i < 25; i++) begin
            kd[40] = ~kd[40];
            step(1);
            if (evt_valid || busy) chk("bounce_quiet", {126'd0, busy, evt_valid}, 128'd0);
            step(1);
            if (evt_valid || busy) chk("bounce_quiet", {126'd0, busy, evt_valid}, 128'd0);
        end
        expect_event("bounce_make", 40, 1'b1);
        wait_idle(300);
        step(10);
        chk("bounce_single", {127'd0, evt_valid}, 128'd0);

        // Reset while an event is pending
        reset = 1'b1; step(1); reset = 1'b0;
        kd = '0; kd[17] = 1'b1; evt_ready = 1'b0;
        wait_valid("r17", 300);
        chk("r17_code", {121'd0, evt_code}, 128'd17);
        reset = 1'b1;
        step(1);
        chk("r17_valid", {127'd0, evt_valid}, 128'd0);
        chk("r17_state", {25'd0, key_state}, 128'd0);
        chk("r17_busy", {127'd0, busy}, 128'd0);
        reset = 1'b0; kd = '0; evt_ready = 1'b1;
        step(10);

        // enabled gates sweep start
        enabled = 1'b0; kd[1] = 1'b1;
        step(30);
        chk("en_off_valid", {127'd0, evt_valid}, 128'd0);
        chk("en_off_busy", {127'd0, busy}, 128'd0);
        enabled = 1'b1;
        expect_event("en_on", 1, 1'b1);
        wait_idle(300);

        // Randomized phase
        for (int c = 0; c < 4000; c++) begin
            evt_ready = ($urandom_range(0, 3) != 0);
            enabled   = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 14) == 0) kd[$urandom_range(1, N)] = ~kd[$urandom_range(1, N)];
            if ($urandom_range(0, 29) == 0) kd[$urandom_range(1, N)] = $urandom_range(0, 1);
            reset = ($urandom_range(0, 799) == 0);
            step(1);
        end
        reset = 1'b0; evt_ready = 1'b1; enabled = 1'b1;
        step(5);
        wait_idle(2000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
